// File: rtl/raster_defs.sv
// ============================================================================
// Module      : raster_defs (package)
// Description : Shared widths, write-select codes and background colour for
//               the triangle rasteriser pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package raster_defs;

  // Default configuration of the rasteriser
  localparam int C_EVAL_BITS  = 7;
  localparam int C_INT_BITS   = 7;
  localparam int C_NUM_TRIS   = 4;
  localparam int C_TRI_IDX_W  = 2;
  localparam int C_Z_BITS     = 8;
  localparam int C_COLOR_W    = 3;

  // Colour index meaning "no triangle here"
  localparam int BG_COLOR = 0;

  // Write-select codes: 0..2 address a vertex, 3 addresses the slot attributes
  typedef enum logic [1:0] {
    WR_SEL_V0   = 2'd0,
    WR_SEL_V1   = 2'd1,
    WR_SEL_V2   = 2'd2,
    WR_SEL_ATTR = 2'd3
  } wr_sel_e;

  // Edge-function width: large enough that the cross product never overflows
  function automatic int edge_width(input int int_bits);
    return 2 * int_bits + 5;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tri_edge_eval.sv
// ============================================================================
// Module      : tri_edge_eval
// Description : One triangle slot. Computes the three edge functions of the
//               incoming pixel (stage 1 registers) and derives coverage from
//               the registered values (feeds stage 2 in the top).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_edge_eval
  import raster_defs::*;
#(
  parameter int EVAL_BITS = C_EVAL_BITS,
  parameter int INT_BITS  = C_INT_BITS
) (
  input  logic                    mclk,
  input  logic                    reset_n,
  input  logic [EVAL_BITS-1:0]    px,
  input  logic [EVAL_BITS-1:0]    py,
  input  logic signed [INT_BITS:0] vx [3],
  input  logic signed [INT_BITS:0] vy [3],
  input  logic                    en,
  output logic                    covered
);

  localparam int E_W = edge_width(INT_BITS);
  // One bit wider than the minimum so vertex/pixel differences never wrap
  localparam int D_W = INT_BITS + 3;

  logic signed [D_W-1:0] px_s, py_s;
  logic signed [D_W-1:0] vx_s [3];
  logic signed [D_W-1:0] vy_s [3];
  logic signed [E_W-1:0] e_d [3];
  logic signed [E_W-1:0] e_q [3];
  logic                  en_d, en_q;
  logic                  all_ge, all_le, all_zero;

  // E = (xb-xa)*(qy-ya) - (yb-ya)*(qx-xa)
  function automatic logic signed [E_W-1:0] edge_fn(
    input logic signed [D_W-1:0] xa, input logic signed [D_W-1:0] ya,
    input logic signed [D_W-1:0] xb, input logic signed [D_W-1:0] yb,
    input logic signed [D_W-1:0] qx, input logic signed [D_W-1:0] qy);
    logic signed [E_W-1:0] dx, dy, qdx, qdy;
    dx  = E_W'(xb - xa);
    dy  = E_W'(yb - ya);
    qdx = E_W'(qx - xa);
    qdy = E_W'(qy - ya);
    return dx * qdy - dy * qdx;
  endfunction

  // Stage-1 next state: widen coordinates and evaluate edges (0,1),(1,2),(2,0)
  always_comb begin
    px_s = {{(D_W-EVAL_BITS){1'b0}}, px};
    py_s = {{(D_W-EVAL_BITS){1'b0}}, py};
    for (int i = 0; i < 3; i++) begin
      vx_s[i] = {{(D_W-INT_BITS-1){vx[i][INT_BITS]}}, vx[i]};
      vy_s[i] = {{(D_W-INT_BITS-1){vy[i][INT_BITS]}}, vy[i]};
    end
    e_d[0] = edge_fn(vx_s[0], vy_s[0], vx_s[1], vy_s[1], px_s, py_s);
    e_d[1] = edge_fn(vx_s[1], vy_s[1], vx_s[2], vy_s[2], px_s, py_s);
    e_d[2] = edge_fn(vx_s[2], vy_s[2], vx_s[0], vy_s[0], px_s, py_s);
    en_d   = en;
  end

  // Stage-1 registers: edge values and the enable they were computed against
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) e_q[i] <= '0;
      en_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) e_q[i] <= e_d[i];
      en_q <= en_d;
    end
  end

  // Coverage: consistent sign on every edge (either winding), boundary inside,
  // but a pixel on which all three edges vanish is a degenerate hit and rejected
  always_comb begin
    all_ge   = 1'b1;
    all_le   = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (e_q[i][E_W-1])                     all_ge   = 1'b0;
      if (!e_q[i][E_W-1] && (e_q[i] != '0))  all_le   = 1'b0;
      if (e_q[i] != '0)                      all_zero = 1'b0;
    end
    covered = en_q & (all_ge | all_le) & ~all_zero;
  end

endmodule

`default_nettype wire

// File: rtl/tri_raster_pipe.sv
// ============================================================================
// Module      : tri_raster_pipe
// Description : 3-stage per-pixel rasteriser for NUM_TRIS flat-shaded
//               triangles with nearest-depth resolve and a double-buffered
//               (shadow/active) triangle bank.
//               Optional macro RASTER_STATS_EN adds the cov_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_raster_pipe
  import raster_defs::*;
#(
  parameter int EVAL_BITS = C_EVAL_BITS,
  parameter int INT_BITS  = C_INT_BITS,
  parameter int NUM_TRIS  = C_NUM_TRIS,
  parameter int TRI_IDX_W = C_TRI_IDX_W,
  parameter int Z_BITS    = C_Z_BITS,
  parameter int COLOR_W   = C_COLOR_W
) (
  input  logic                     mclk,
  input  logic                     reset_n,
  input  logic                     frame_sync,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [TRI_IDX_W-1:0]     wr_tri,
  input  logic [1:0]               wr_sel,
  input  logic signed [INT_BITS:0] wr_x,
  input  logic signed [INT_BITS:0] wr_y,
  input  logic [Z_BITS-1:0]        wr_z,
  input  logic [COLOR_W-1:0]       wr_color,
  input  logic                     wr_en,
  input  logic                     pix_valid,
  input  logic [EVAL_BITS-1:0]     pix_x,
  input  logic [EVAL_BITS-1:0]     pix_y,
  output logic                     out_valid,
  output logic [COLOR_W-1:0]       color_idx
`ifdef RASTER_STATS_EN
  ,
  output logic [2*EVAL_BITS:0]     cov_count
`endif
);

  localparam logic [COLOR_W-1:0] BG = COLOR_W'(BG_COLOR);

  // Triangle banks
  logic signed [INT_BITS:0] sh_x_d  [NUM_TRIS][3], sh_x_q  [NUM_TRIS][3];
  logic signed [INT_BITS:0] sh_y_d  [NUM_TRIS][3], sh_y_q  [NUM_TRIS][3];
  logic signed [INT_BITS:0] act_x_d [NUM_TRIS][3], act_x_q [NUM_TRIS][3];
  logic signed [INT_BITS:0] act_y_d [NUM_TRIS][3], act_y_q [NUM_TRIS][3];
  logic [Z_BITS-1:0]        sh_z_d  [NUM_TRIS], sh_z_q  [NUM_TRIS];
  logic [Z_BITS-1:0]        act_z_d [NUM_TRIS], act_z_q [NUM_TRIS];
  logic [COLOR_W-1:0]       sh_c_d  [NUM_TRIS], sh_c_q  [NUM_TRIS];
  logic [COLOR_W-1:0]       act_c_d [NUM_TRIS], act_c_q [NUM_TRIS];
  logic [NUM_TRIS-1:0]      sh_en_d, sh_en_q, act_en_d, act_en_q;
  logic                     wr_fire;

  // Pipeline
  logic [NUM_TRIS-1:0]      cov_w;
  logic                     s1_vld_d, s1_vld_q;
  logic [Z_BITS-1:0]        s1_z_d [NUM_TRIS], s1_z_q [NUM_TRIS];
  logic [COLOR_W-1:0]       s1_c_d [NUM_TRIS], s1_c_q [NUM_TRIS];
  logic                     s2_vld_d, s2_vld_q;
  logic [NUM_TRIS-1:0]      s2_cov_d, s2_cov_q;
  logic [Z_BITS-1:0]        s2_z_d [NUM_TRIS], s2_z_q [NUM_TRIS];
  logic [COLOR_W-1:0]       s2_c_d [NUM_TRIS], s2_c_q [NUM_TRIS];
  logic                     out_vld_d, out_vld_q;
  logic [COLOR_W-1:0]       color_d, color_q;
  logic                     hit_found;
  logic [Z_BITS-1:0]        best_z;
  logic [COLOR_W-1:0]       best_c;

  // Writes are refused only while the shadow is being copied to the active bank
  assign wr_ready = ~frame_sync;
  assign wr_fire  = wr_valid & wr_ready & (int'(wr_tri) < NUM_TRIS);

  // Bank next state: shadow writes, whole-bank copy on frame_sync
  always_comb begin
    sh_x_d   = sh_x_q;   sh_y_d   = sh_y_q;
    sh_z_d   = sh_z_q;   sh_c_d   = sh_c_q;   sh_en_d  = sh_en_q;
    act_x_d  = act_x_q;  act_y_d  = act_y_q;
    act_z_d  = act_z_q;  act_c_d  = act_c_q;  act_en_d = act_en_q;
    if (frame_sync) begin
      act_x_d  = sh_x_q;  act_y_d = sh_y_q;
      act_z_d  = sh_z_q;  act_c_d = sh_c_q;  act_en_d = sh_en_q;
    end
    if (wr_fire) begin
      if (wr_sel == WR_SEL_ATTR) begin
        sh_z_d[wr_tri]  = wr_z;
        sh_c_d[wr_tri]  = wr_color;
        sh_en_d[wr_tri] = wr_en;
      end else begin
        sh_x_d[wr_tri][wr_sel] = wr_x;
        sh_y_d[wr_tri][wr_sel] = wr_y;
      end
    end
  end

  // Bank registers
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_TRIS; k++) begin
        for (int v = 0; v < 3; v++) begin
          sh_x_q[k][v]  <= '0;  sh_y_q[k][v]  <= '0;
          act_x_q[k][v] <= '0;  act_y_q[k][v] <= '0;
        end
        sh_z_q[k]  <= '0;  sh_c_q[k]  <= '0;
        act_z_q[k] <= '0;  act_c_q[k] <= '0;
      end
      sh_en_q  <= '0;
      act_en_q <= '0;
    end else begin
      sh_x_q  <= sh_x_d;   sh_y_q  <= sh_y_d;
      sh_z_q  <= sh_z_d;   sh_c_q  <= sh_c_d;   sh_en_q  <= sh_en_d;
      act_x_q <= act_x_d;  act_y_q <= act_y_d;
      act_z_q <= act_z_d;  act_c_q <= act_c_d;  act_en_q <= act_en_d;
    end
  end

  // Per-slot edge evaluation and coverage
  generate
    for (genvar k = 0; k < NUM_TRIS; k++) begin : g_slot
      tri_edge_eval #(
        .EVAL_BITS (EVAL_BITS),
        .INT_BITS  (INT_BITS)
      ) u_eval (
        .mclk    (mclk),
        .reset_n (reset_n),
        .px      (pix_x),
        .py      (pix_y),
        .vx      (act_x_q[k]),
        .vy      (act_y_q[k]),
        .en      (act_en_q[k]),
        .covered (cov_w[k])
      );
    end
  endgenerate

  // Pipeline next state: depth/colour travel with the pixel so a frame_sync
  // mid-flight cannot mix banks; stage 3 picks the nearest covering slot
  always_comb begin
    s1_vld_d = pix_valid;
    s1_z_d   = act_z_q;
    s1_c_d   = act_c_q;
    s2_vld_d = s1_vld_q;
    s2_cov_d = cov_w;
    s2_z_d   = s1_z_q;
    s2_c_d   = s1_c_q;

    hit_found = 1'b0;
    best_z    = '0;
    best_c    = BG;
    // Strict less-than keeps the lowest slot index on equal depth
    for (int k = 0; k < NUM_TRIS; k++) begin
      if (s2_cov_q[k] && (!hit_found || (s2_z_q[k] < best_z))) begin
        hit_found = 1'b1;
        best_z    = s2_z_q[k];
        best_c    = s2_c_q[k];
      end
    end
    out_vld_d = s2_vld_q;
    color_d   = s2_vld_q ? best_c : BG;
  end

  // Pipeline registers; async reset flushes everything immediately
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_cov_q  <= '0;
      out_vld_q <= 1'b0;
      color_q   <= BG;
      for (int k = 0; k < NUM_TRIS; k++) begin
        s1_z_q[k] <= '0;  s1_c_q[k] <= '0;
        s2_z_q[k] <= '0;  s2_c_q[k] <= '0;
      end
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_z_q    <= s1_z_d;
      s1_c_q    <= s1_c_d;
      s2_vld_q  <= s2_vld_d;
      s2_cov_q  <= s2_cov_d;
      s2_z_q    <= s2_z_d;
      s2_c_q    <= s2_c_d;
      out_vld_q <= out_vld_d;
      color_q   <= color_d;
    end
  end

  assign out_valid = out_vld_q;
  assign color_idx = color_q;

`ifdef RASTER_STATS_EN
  localparam int CNT_W = 2 * EVAL_BITS + 1;

  logic [CNT_W-1:0] frm_cnt_d, frm_cnt_q, cov_count_d, cov_count_q, frm_inc;

  // Count covered output pixels per frame (saturating); publish on frame_sync
  always_comb begin
    frm_inc = frm_cnt_q;
    if (out_vld_q && (color_q != BG) && (frm_cnt_q != '1))
      frm_inc = frm_cnt_q + CNT_W'(1);
    frm_cnt_d   = frm_inc;
    cov_count_d = cov_count_q;
    if (frame_sync) begin
      cov_count_d = frm_inc;
      frm_cnt_d   = '0;
    end
  end

  // Statistics registers
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      frm_cnt_q   <= '0;
      cov_count_q <= '0;
    end else begin
      frm_cnt_q   <= frm_cnt_d;
      cov_count_q <= cov_count_d;
    end
  end

  assign cov_count = cov_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tri_raster_pipe.sv
// ============================================================================
// Module      : tb_tri_raster_pipe
// Description : Self-checking bench for tri_raster_pipe. Directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tri_raster_pipe;

  localparam int NT = 3;   // three slots so that wr_tri=3 is out of range

  logic              mclk = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_sync = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [1:0]        wr_tri = '0;
  logic [1:0]        wr_sel = '0;
  logic signed [7:0] wr_x = '0;
  logic signed [7:0] wr_y = '0;
  logic [7:0]        wr_z = '0;
  logic [2:0]        wr_color = '0;
  logic              wr_en = 1'b0;
  logic              pix_valid = 1'b0;
  logic [6:0]        pix_x = '0;
  logic [6:0]        pix_y = '0;
  logic              out_valid;
  logic [2:0]        color_idx;

  tri_raster_pipe #(
    .EVAL_BITS(7), .INT_BITS(7), .NUM_TRIS(NT), .TRI_IDX_W(2), .Z_BITS(8), .COLOR_W(3)
  ) dut (
    .mclk(mclk), .reset_n(reset_n), .frame_sync(frame_sync),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_tri(wr_tri), .wr_sel(wr_sel),
    .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z), .wr_color(wr_color), .wr_en(wr_en),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .out_valid(out_valid), .color_idx(color_idx)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: shadow and active triangle sets
  int sh_x[4][3], sh_y[4][3], sh_z[4], sh_c[4];
  bit sh_en[4];
  int ac_x[4][3], ac_y[4][3], ac_z[4], ac_c[4];
  bit ac_en[4];
  int hist[$];            // expected colour per driven cycle, -1 = not valid
  logic       obs_valid, obs_ready;
  logic [2:0] obs_color;

  function automatic int model_color(int px, int py);
    int best, bz, j, e;
    bit pos, neg;
    best = -1; bz = 0;
    for (int k = 0; k < NT; k++) begin
      if (ac_en[k]) begin
        pos = 0; neg = 0;
        for (int i = 0; i < 3; i++) begin
          j = (i + 1) % 3;
          e = (ac_x[k][j] - ac_x[k][i]) * (py - ac_y[k][i])
            - (ac_y[k][j] - ac_y[k][i]) * (px - ac_x[k][i]);
          if (e > 0) pos = 1;
          if (e < 0) neg = 1;
        end
        if ((pos || neg) && !(pos && neg) && (best < 0 || ac_z[k] < bz)) begin
          best = k; bz = ac_z[k];
        end
      end
    end
    return (best < 0) ? 0 : ac_c[best];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      for (int v = 0; v < 3; v++) begin
        sh_x[k][v] = 0; sh_y[k][v] = 0; ac_x[k][v] = 0; ac_y[k][v] = 0;
      end
      sh_z[k] = 0; sh_c[k] = 0; sh_en[k] = 0;
      ac_z[k] = 0; ac_c[k] = 0; ac_en[k] = 0;
    end
    hist = {};
    hist.push_back(-1);
    hist.push_back(-1);
  endtask

  // One clock of stimulus; the model follows the same edge
  task automatic step(input bit v, input int x, input int y, input bit fs,
                      input bit wv, input int wt, input int ws, input int wx,
                      input int wy, input int wz, input int wc, input bit we);
    @(negedge mclk);
    pix_valid = v; pix_x = 7'(x); pix_y = 7'(y); frame_sync = fs;
    wr_valid = wv; wr_tri = 2'(wt); wr_sel = 2'(ws); wr_x = 8'(wx); wr_y = 8'(wy);
    wr_z = 8'(wz); wr_color = 3'(wc); wr_en = we;
    hist.push_back(v ? model_color(x, y) : -1);
    #1 obs_ready = wr_ready;
    @(posedge mclk);
    if (fs) begin
      ac_x = sh_x; ac_y = sh_y; ac_z = sh_z; ac_c = sh_c; ac_en = sh_en;
    end else if (wv && wt < NT) begin
      if (ws == 3) begin sh_z[wt] = wz; sh_c[wt] = wc; sh_en[wt] = we; end
      else begin sh_x[wt][ws] = wx; sh_y[wt][ws] = wy; end
    end
    #1 obs_valid = out_valid; obs_color = color_idx;
  endtask

  task automatic pix(input int x, input int y);  step(1, x, y, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle();                          step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic sync();                          step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wvert(input int t, input int i, input int x, input int y);
    step(0, 0, 0, 0, 1, t, i, x, y, 0, 0, 0);
  endtask
  task automatic wattr(input int t, input int z, input int c, input bit en);
    step(0, 0, 0, 0, 1, t, 3, 0, 0, z, c, en);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge mclk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (color_idx !== 3'd0) begin errors++; $display("FAIL reset_color got %0d want 0", color_idx); end
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %0b want 1", wr_ready); end
    @(negedge mclk);
    reset_n = 1'b1;
    clear_model();
    idle();
    checks++;
    if (obs_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %0b want 0", obs_valid); end
  endtask

  task automatic test_basic();
    int px[4], py[4], ex[4];
    px = '{20, 50, 10, 35}; py = '{15, 30, 10, 10}; ex = '{1, 0, 1, 1};
    wvert(0, 0, 10, 10); wvert(0, 1, 60, 10); wvert(0, 2, 10, 36);
    wattr(0, 1, 1, 1);
    sync();
    for (int i = 0; i < 4; i++) begin
      pix(px[i], py[i]);
      idle();
      checks++;
      if (obs_valid !== 1'b0) begin
        errors++; $display("FAIL basic_latency_early pix%0d valid=%0b want 0", i, obs_valid);
      end
      idle();
      checks++;
      if (obs_valid !== 1'b1 || obs_color !== 3'(ex[i])) begin
        errors++;
        $display("FAIL basic_pix(%0d,%0d) got valid=%0b color=%0d want valid=1 color=%0d",
                 px[i], py[i], obs_valid, obs_color, ex[i]);
      end
    end
  endtask

  task automatic test_depth();
    wvert(1, 0, 0, 0); wvert(1, 1, 100, 0); wvert(1, 2, 0, 100);
    wattr(1, 0, 2, 1);
    sync();
    pix(20, 15); idle(); idle();
    checks++;
    if (obs_valid !== 1'b1 || obs_color !== 3'd2) begin
      errors++; $display("FAIL depth_nearer got valid=%0b color=%0d want 1/2", obs_valid, obs_color);
    end
    wattr(1, 1, 2, 1);
    sync();
    pix(20, 15); idle(); idle();
    checks++;
    if (obs_valid !== 1'b1 || obs_color !== 3'd1) begin
      errors++; $display("FAIL depth_tie got valid=%0b color=%0d want 1/1", obs_valid, obs_color);
    end
  endtask

  task automatic test_shadow();
    wattr(0, 1, 5, 1);
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("FAIL shadow_ready_normal got %0b want 1", obs_ready); end
    pix(20, 15); idle(); idle();
    checks++;
    if (obs_color !== 3'd1) begin errors++; $display("FAIL shadow_no_sync got %0d want 1", obs_color); end
    sync();
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL shadow_ready_sync got %0b want 0", obs_ready); end
    pix(20, 15); idle(); idle();
    checks++;
    if (obs_color !== 3'd5) begin errors++; $display("FAIL shadow_after_sync got %0d want 5", obs_color); end
  endtask

  task automatic test_collinear_oob();
    wattr(0, 0, 1, 0); wattr(1, 0, 2, 0);
    wvert(2, 0, 0, 0); wvert(2, 1, 50, 50); wvert(2, 2, 100, 100);
    wattr(2, 0, 3, 1);
    sync();
    pix(25, 25); idle(); idle();
    checks++;
    if (obs_valid !== 1'b1 || obs_color !== 3'd0) begin
      errors++; $display("FAIL collinear got valid=%0b color=%0d want 1/0", obs_valid, obs_color);
    end
    wvert(3, 0, 0, 0); wvert(3, 1, 100, 0); wvert(3, 2, 0, 100);
    wattr(3, 0, 4, 1);
    sync();
    pix(25, 25); idle(); idle();
    checks++;
    if (obs_valid !== 1'b1 || obs_color !== 3'd0) begin
      errors++; $display("FAIL oob_slot got valid=%0b color=%0d want 1/0", obs_valid, obs_color);
    end
  endtask

  task automatic test_random();
    int r, x, y, e;
    bit v;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      v = ($urandom_range(0, 4) != 0);
      x = $urandom_range(0, 127);
      y = $urandom_range(0, 127);
      if (r == 0)
        step(v, x, y, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      else if (r <= 3)
        step(v, x, y, 0, 1, $urandom_range(0, 3), $urandom_range(0, 3),
             int'($urandom_range(0, 147)) - 20, int'($urandom_range(0, 147)) - 20,
             $urandom_range(0, 3), $urandom_range(0, 7), ($urandom_range(0, 3) != 0));
      else
        step(v, x, y, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      e = hist[hist.size() - 3];
      checks++;
      if (obs_valid !== (e >= 0) || obs_color !== 3'((e < 0) ? 0 : e)) begin
        errors++;
        $display("FAIL random_cycle%0d got valid=%0b color=%0d want valid=%0b color=%0d",
                 n, obs_valid, obs_color, (e >= 0), (e < 0) ? 0 : e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int e;
    wvert(0, 0, 0, 0); wvert(0, 1, 120, 0); wvert(0, 2, 0, 120);
    wattr(0, 0, 6, 1);
    sync();
    for (int n = 0; n < 5; n++) begin
      pix(20, 15);
      e = hist[hist.size() - 3];
      checks++;
      if (obs_valid !== (e >= 0) || obs_color !== 3'((e < 0) ? 0 : e)) begin
        errors++; $display("FAIL midreset_stream%0d got %0b/%0d want %0b/%0d",
                           n, obs_valid, obs_color, (e >= 0), (e < 0) ? 0 : e);
      end
    end
    @(negedge mclk);
    #2 reset_n = 1'b0;
    pix_valid = 1'b0; frame_sync = 1'b0; wr_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || color_idx !== 3'd0) begin
      errors++; $display("FAIL midreset_immediate got %0b/%0d want 0/0", out_valid, color_idx);
    end
    @(posedge mclk);
    @(negedge mclk);
    reset_n = 1'b1;
    clear_model();
    for (int n = 0; n < 6; n++) begin
      pix(20, 15);
      e = hist[hist.size() - 3];
      checks++;
      if (obs_valid !== (e >= 0) || obs_color !== 3'((e < 0) ? 0 : e)) begin
        errors++; $display("FAIL midreset_after%0d got %0b/%0d want %0b/%0d",
                           n, obs_valid, obs_color, (e >= 0), (e < 0) ? 0 : e);
      end
    end
    checks++;
    if (obs_valid !== 1'b1 || obs_color !== 3'd0) begin
      errors++; $display("FAIL midreset_banks_cleared got %0b/%0d want 1/0", obs_valid, obs_color);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_depth();
    test_shadow();
    test_collinear_oob();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
